// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO read-side stream controller.
package fifo_rd_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned BUF_DEPTH      = 2;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for fifo_stream_reader.
interface fifo_stream_reader_if
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned CNT_W  = 16
);

  logic              en;
  logic              fifo_empty;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_dout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [CNT_W-1:0]  frame_cnt;
  logic              busy;

  modport master (
    input  en, fifo_empty, fifo_dout, m_ready,
    output fifo_rd, m_data, m_valid, m_last, frame_cnt, busy
  );

  modport slave (
    output en, fifo_empty, fifo_dout, m_ready,
    input  fifo_rd, m_data, m_valid, m_last, frame_cnt, busy
  );

endinterface

// File: rtl/fifo_stream_reader_stream_buf2.sv
// Two-entry register buffer: tail write, head read, occupancy out.
module stream_buf2
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd,
  output occ_t              occ,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic              rptr_q, rptr_d;
  logic              wptr_q, wptr_d;
  occ_t              occ_q, occ_d;

  always_comb begin
    rptr_d = rptr_q ^ rd;
    wptr_d = wptr_q ^ wr;
    occ_d  = occ_q + occ_t'(wr) - occ_t'(rd);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      rptr_q <= 1'b0;
      wptr_q <= 1'b0;
      occ_q  <= '0;
    end else begin
      if (wr) mem_q[wptr_q] <= wdata;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      occ_q  <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = mem_q[rptr_q];

  occ_bound_a : assert property (@(posedge clk) disable iff (!rst) occ_q <= occ_t'(BUF_DEPTH));
  no_overrun_a : assert property (@(posedge clk) disable iff (!rst)
    !(wr && !rd && occ_q == occ_t'(BUF_DEPTH)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream with frame marking and counting.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned CNT_W     = 16
) (
  input logic                 clk,
  input logic                 rst,
  fifo_stream_reader_if.master bus
);

  localparam int unsigned     IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic              inflight_q;
  occ_t              occ;
  logic [DATA_W-1:0] head;
  logic              valid, fire, last, rd;
  logic [2:0]        credit;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  stream_buf2 #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .wr   (inflight_q),
    .wdata(bus.fifo_dout),
    .rd   (fire),
    .occ  (occ),
    .head (head)
  );

  always_comb begin
    valid  = (occ != '0);
    fire   = valid & bus.m_ready;
    last   = valid & (idx_q == LAST_IDX);
    // Slots already claimed after this edge; fire implies occ >= 1 so no underflow.
    credit = 3'(occ) + 3'(inflight_q) - 3'(fire);
    rd     = rst & bus.en & ~bus.fifo_empty & (credit <= 3'd1);
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    if (fire) begin
      if (last) begin
        idx_d = '0;
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= rd;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.fifo_rd   = rd;
  assign bus.m_data    = head;
  assign bus.m_valid   = valid;
  assign bus.m_last    = last;
  assign bus.frame_cnt = cnt_q;
  assign bus.busy      = inflight_q | valid;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: FIFO models feed two readers, a scoreboard checks every delivered byte.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_W(8), .CNT_W(16)) ia ();
  fifo_stream_reader_if #(.DATA_W(8), .CNT_W(2))  ib ();

  fifo_stream_reader #(.DATA_W(8), .FRAME_LEN(16), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .bus(ia)
  );
  fifo_stream_reader #(.DATA_W(8), .FRAME_LEN(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .bus(ib)
  );

  // Registered-read FIFO models sharing rst; reset empties them.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] wp_a, rp_a, wp_b, rp_b;

  assign ia.fifo_empty = (wp_a == rp_a);
  assign ib.fifo_empty = (wp_b == rp_b);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp_a <= wp_a;
      rp_b <= wp_b;
      ia.fifo_dout <= '0;
      ib.fifo_dout <= '0;
    end else begin
      if (ia.fifo_rd && !ia.fifo_empty) begin
        ia.fifo_dout <= mem_a[rp_a];
        rp_a <= rp_a + 8'd1;
      end
      if (ib.fifo_rd && !ib.fifo_empty) begin
        ib.fifo_dout <= mem_b[rp_b];
        rp_b <= rp_b + 8'd1;
      end
    end
  end

  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  int n_total = 0, n_pass = 0;
  int pops_a = 0, fires_a = 0, idx_a = 0, frames_a = 0;
  int frames_b = 0;
  int p0, f0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load_a(input logic [7:0] d);
    mem_a[wp_a] = d;
    wp_a = wp_a + 8'd1;
    exp_a.push_back(d);
  endtask

  task automatic load_b(input logic [7:0] d);
    mem_b[wp_b] = d;
    wp_b = wp_b + 8'd1;
    exp_b.push_back(d);
  endtask

  // Samples handshakes just before the edge, checks frame counters just after it.
  task automatic tick();
    logic [7:0] d;
    logic       l;
    @(negedge clk);
    chk("a_rd_while_empty", 32'(ia.fifo_rd & ia.fifo_empty), 32'd0);
    chk("b_rd_while_empty", 32'(ib.fifo_rd & ib.fifo_empty), 32'd0);
    if (ia.fifo_rd && !ia.fifo_empty) pops_a++;
    if (ia.m_valid && ia.m_ready) begin
      fires_a++;
      chk("a_byte_expected", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0) begin
        d = exp_a.pop_front();
        l = (idx_a == 15);
        chk("a_data", 32'(ia.m_data), 32'(d));
        chk("a_last", 32'(ia.m_last), 32'(l));
        if (l) begin
          idx_a = 0;
          frames_a++;
        end else begin
          idx_a++;
        end
      end
    end
    if (ib.m_valid && ib.m_ready) begin
      chk("b_byte_expected", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0) begin
        d = exp_b.pop_front();
        chk("b_data", 32'(ib.m_data), 32'(d));
        chk("b_last", 32'(ib.m_last), 32'd1);
        frames_b = (frames_b + 1) % 4;
      end
    end
    @(posedge clk);
    #1;
    chk("a_frame_cnt", 32'(ia.frame_cnt), 32'(frames_a));
    chk("b_frame_cnt", 32'(ib.frame_cnt), 32'(frames_b));
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_a.size() + exp_b.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_a.size() + exp_b.size()), 32'd0);
  endtask

  initial begin
    wp_a = '0;
    wp_b = '0;
    ia.en = 1'b0;
    ia.m_ready = 1'b0;
    ib.en = 1'b0;
    ib.m_ready = 1'b1;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_fifo_rd", 32'(ia.fifo_rd), 32'd0);
    chk("rst_m_valid", 32'(ia.m_valid), 32'd0);
    chk("rst_busy", 32'(ia.busy), 32'd0);
    chk("rst_frame_cnt", 32'(ia.frame_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Streaming: first byte two edges after the first pop, then one per cycle.
    ia.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) load_a(8'(i));
    ia.en = 1'b1;
    #1;
    chk("stream_first_rd", 32'(ia.fifo_rd), 32'd1);
    tick();
    chk("stream_valid_e1", 32'(ia.m_valid), 32'd0);
    chk("stream_busy_e1", 32'(ia.busy), 32'd1);
    tick();
    chk("stream_valid_e2", 32'(ia.m_valid), 32'd1);
    chk("stream_data_e2", 32'(ia.m_data), 32'h00);
    f0 = fires_a;
    repeat (16) tick();
    chk("stream_throughput", 32'(fires_a - f0), 32'd16);
    chk("stream_frame_cnt", 32'(ia.frame_cnt), 32'd1);
    chk("stream_idle_busy", 32'(ia.busy), 32'd0);

    // Backpressure: buffer fills, pops stop, head holds until resume.
    for (int i = 0; i < 16; i++) load_a(8'(8'h10 + i));
    repeat (6) tick();
    ia.m_ready = 1'b0;
    repeat (10) begin
      tick();
      chk("stall_valid", 32'(ia.m_valid), 32'd1);
      chk("stall_data", 32'(ia.m_data), 32'(exp_a[0]));
      chk("stall_rd", 32'(ia.fifo_rd), 32'd0);
    end
    chk("stall_outstanding", 32'(pops_a - fires_a), 32'd2);
    ia.m_ready = 1'b1;
    drain("bp_drain", 40);
    tick();
    chk("bp_frame_cnt", 32'(ia.frame_cnt), 32'd2);

    // Empty FIFO after three bytes.
    p0 = pops_a;
    f0 = fires_a;
    for (int i = 0; i < 3; i++) load_a(8'(8'h20 + i));
    repeat (10) tick();
    chk("empty_pops", 32'(pops_a - p0), 32'd3);
    chk("empty_fires", 32'(fires_a - f0), 32'd3);
    chk("empty_rd", 32'(ia.fifo_rd), 32'd0);
    chk("empty_valid", 32'(ia.m_valid), 32'd0);
    chk("empty_busy", 32'(ia.busy), 32'd0);

    // en drop with one byte buffered and one in flight.
    ia.m_ready = 1'b0;
    p0 = pops_a;
    for (int i = 0; i < 4; i++) load_a(8'(8'h30 + i));
    tick();
    tick();
    chk("en_pre_pops", 32'(pops_a - p0), 32'd2);
    chk("en_pre_valid", 32'(ia.m_valid), 32'd1);
    ia.en = 1'b0;
    ia.m_ready = 1'b1;
    repeat (6) tick();
    chk("en_off_pops", 32'(pops_a - p0), 32'd2);
    chk("en_off_left", 32'(exp_a.size()), 32'd2);
    chk("en_off_rd", 32'(ia.fifo_rd), 32'd0);
    chk("en_off_fifo_nonempty", 32'(ia.fifo_empty), 32'd0);
    chk("en_off_valid", 32'(ia.m_valid), 32'd0);
    ia.en = 1'b1;
    drain("en_drain", 20);

    // Reset with a buffered byte and a byte in flight.
    ia.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) load_a(8'(8'h50 + i));
    tick();
    tick();
    chk("mid_busy", 32'(ia.busy), 32'd1);
    rst = 1'b0;
    exp_a.delete();
    idx_a = 0;
    frames_a = 0;
    frames_b = 0;
    #1;
    chk("mid_rst_rd", 32'(ia.fifo_rd), 32'd0);
    chk("mid_rst_valid", 32'(ia.m_valid), 32'd0);
    chk("mid_rst_last", 32'(ia.m_last), 32'd0);
    chk("mid_rst_data", 32'(ia.m_data), 32'd0);
    chk("mid_rst_busy", 32'(ia.busy), 32'd0);
    chk("mid_rst_cnt", 32'(ia.frame_cnt), 32'd0);
    tick();
    rst = 1'b1;
    ia.m_ready = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", 32'(ia.m_valid), 32'd0);
    for (int i = 0; i < 16; i++) load_a(8'(8'h60 + i));
    drain("post_rst_drain", 40);
    tick();
    chk("post_rst_frames", 32'(ia.frame_cnt), 32'd1);

    // FRAME_LEN=1, 2-bit counter: last on every byte, count wraps.
    for (int i = 0; i < 5; i++) load_b(8'(8'hA0 + i));
    ib.en = 1'b1;
    drain("wrap_drain", 20);
    tick();
    chk("wrap_frame_cnt", 32'(ib.frame_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
